axil_regbank: RTL and testbench
===============================

# axil_regbank

Parametrised AXI4-Lite slave register bank, the successor to the fixed four-register HDMI control slave. It exposes NUM_REGS registers of C_S_AXI_DATA_WIDTH bits with byte strobes and per-register read-only and write-pulse modes. It accepts AW and W in any order and drives SLVERR for addresses outside the bank. It sits between the AXI interconnect and the HDMI timing and pattern logic: control registers fan out as flat vectors and status registers fan in.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; must be 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6: address width; must be at least clog2(NUM_REGS) + clog2(C_S_AXI_DATA_WIDTH/8).
- NUM_REGS, 16: number of registers; range 1..256.
- RO_MASK, 0: NUM_REGS bits; bit i set means register i is read-only and returns the matching status_i slice.
- W1P_MASK, 0: NUM_REGS bits; bit i set means register i is write-pulse; it reads as 0.
- S_AXI_ACLK  in  1  the single clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  write protection; ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  read protection; ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- ctrl_o  out  NUM_REGS*C_S_AXI_DATA_WIDTH  register contents; register i occupies slice i.
- status_i  in  NUM_REGS*C_S_AXI_DATA_WIDTH  status inputs; only slices with the RO_MASK bit set are used.
- wr_pulse_o  out  NUM_REGS  one-cycle strobe for each register that takes a write.

## Operation
- Register index = ADDR[C_S_AXI_ADDR_WIDTH-1 : clog2(DW/8)]. Low address bits are ignored, so unaligned addresses address the containing word.
- If the index is NUM_REGS or above, the response is SLVERR (2'b10): no register is written and RDATA is 0. Every other access responds OKAY (2'b00).
- Write FSM states are W_IDLE, W_HAVE_A, W_HAVE_D and W_RESP.
  - AW alone moves W_IDLE to W_HAVE_A; W alone moves W_IDLE to W_HAVE_D.
  - Both handshakes in the same cycle, or the missing one arriving later, move to W_RESP.
  - W_RESP returns to W_IDLE on BREADY.
- AWREADY is high only in W_IDLE or W_HAVE_D. WREADY is high only in W_IDLE or W_HAVE_A.
- Commit happens on the cycle the FSM enters W_RESP. For each byte lane k with WSTRB[k]=1, reg[idx] byte k takes WDATA byte k. wr_pulse_o[idx] is 1 for that single cycle even if WSTRB is 0.
- RO register: the write is ignored, the response is OKAY and wr_pulse_o still fires.
- W1P register: storage is updated for that one cycle only and clears to 0 on the next cycle. ctrl_o therefore carries a one-cycle pulse of the written bits.
- Read FSM states are R_IDLE and R_DATA.
  - ARREADY = 1 in R_IDLE.
  - On AR handshake, RDATA and RRESP are registered and the FSM moves to R_DATA.
  - R_DATA returns to R_IDLE on RREADY.
  - Read source is status_i for RO registers, 0 for W1P registers, storage otherwise.
- Read and write FSMs are independent. If an AR handshake and a write commit to the same register fall in the same cycle, the read returns the pre-write value.
- RDATA, RRESP and BRESP hold stable while the corresponding VALID is high and READY is low.

## Timing
- Reset values, applied on the first rising edge with S_AXI_ARESET=1:
  - all storage = 0 and ctrl_o = 0;
  - wr_pulse_o = 0;
  - BVALID = 0, RVALID = 0, BRESP = 0, RRESP = 0, RDATA = 0;
  - AWREADY = WREADY = ARREADY = 1 (combinational from the idle states).
- Reset mid-transaction aborts it: no commit, no response, FSMs return to idle.
- Write latency: BVALID rises 1 cycle after the later of the AW and W handshakes; ctrl_o updates in that same cycle.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Back-to-back throughput is one write per 2 cycles and one read per 2 cycles when BREADY and RREADY are held high.

## Structure
- Package axil_regbank_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the wr_state_t and rd_state_t enums;
  - the function reg_index(addr).
- Sub-module axil_regbank_wstrb_merge: combinational byte-lane merge of old data, new data and strobe, instantiated once.

## Test plan
- Sequential write/read, DW=32, NUM_REGS=16: write 0x1..0x4 to 0x0, 0x4, 0x8, 0xC, then read back. Required: reads return 0x1..0x4, all BRESP/RRESP OKAY, BVALID 1 cycle after the handshake.
- Strobes: write 0xFFFFFFFF to 0x0, then write 0x12345678 with WSTRB=4'b0101. Required: read returns 0xFF34FF78.
- Ordering: W presented 3 cycles before AW, then AW presented 3 cycles before W on the next write. Required: both commit correctly; AWREADY is low while in W_HAVE_A and WREADY is low while in W_HAVE_D.
- Mode masks: with RO_MASK bit 2 set and status_i[2]=0xCAFE0001, write 0x5 to 0x8; with W1P_MASK bit 3 set, write 0x9 to 0xC. Required:
  - reading 0x8 returns 0xCAFE0001 with OKAY;
  - ctrl_o[3] = 0x9 for exactly 1 cycle;
  - reading 0xC returns 0.
- Error and backpressure: write 0x7 to 0x40 with NUM_REGS=16, holding BREADY low for 5 cycles. Required: BRESP=SLVERR held stable with BVALID high; no ctrl_o change; a read of 0x40 returns 0 with SLVERR.
- Reset mid-operation: assert S_AXI_ARESET in W_HAVE_A. Required: next cycle all outputs are at their reset values, and no register holds the pending data.

Source files
------------

// File: rtl/axil_regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Word index of a byte address; lsb is log2 of the bytes per word.
    function automatic logic [31:0] reg_index(input logic [31:0] addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/axil_regbank_wstrb_merge.sv
// Byte-lane merge: each lane takes the new byte when its strobe is set.
module axil_regbank_wstrb_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_i,
    input  logic [DW-1:0]   new_i,
    input  logic [DW/8-1:0] strb_i,
    output logic [DW-1:0]   data_o
);

    // Select old or new byte per lane.
    always_comb begin
        data_o = old_i;
        for (int unsigned k = 0; k < DW / 8; k++) begin
            if (strb_i[k]) begin
                data_o[k*8 +: 8] = new_i[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank with byte strobes, read-only status
// registers and write-pulse registers. AW and W may arrive in any order.
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0] W1P_MASK = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS-1:0]                    wr_pulse_o
);

    localparam int DW      = C_S_AXI_DATA_WIDTH;
    localparam int AW      = C_S_AXI_ADDR_WIDTH;
    localparam int NB      = DW / 8;
    localparam int IDX_LSB = $clog2(NB);
    localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic [AW-1:0]       awaddr_q;
    logic [DW-1:0]       wdata_q;
    logic [NB-1:0]       wstrb_q;
    logic [1:0]          bresp_q;
    logic [1:0]          rresp_q;
    logic [DW-1:0]       rdata_q;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];
    logic [DW-1:0]       status_a [NUM_REGS];

    logic aw_hs, w_hs, ar_hs, commit;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NB-1:0]    wr_strb;
    logic [31:0]      wr_addr32, rd_addr32, wr_idx32, rd_idx32;
    logic [SEL_W-1:0] wr_sel, rd_sel;
    logic             wr_in_range, rd_in_range;
    logic [DW-1:0]    old_word, merged, rd_word;
    logic [1:0]       rd_resp;
    logic             unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_idx32, rd_idx32};

    assign S_AXI_AWREADY = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_D);
    assign S_AXI_WREADY  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_A);
    assign S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (rd_state_q == R_IDLE);
    assign S_AXI_RVALID  = (rd_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse_o    = wr_pulse_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write FSM next state; commit is the transition into W_RESP.
    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = W_RESP;
                else if (aw_hs)    wr_state_d = W_HAVE_A;
                else if (w_hs)     wr_state_d = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)         wr_state_d = W_RESP;
            W_HAVE_D: if (aw_hs)        wr_state_d = W_RESP;
            W_RESP:   if (S_AXI_BREADY) wr_state_d = W_IDLE;
            default:                    wr_state_d = W_IDLE;
        endcase
        commit = (wr_state_q != W_RESP) && (wr_state_d == W_RESP);
    end

    // Commit operands come from the live bus when the handshake is this cycle, else from the holding registers.
    always_comb begin
        wr_addr   = aw_hs ? S_AXI_AWADDR : awaddr_q;
        wr_data   = w_hs  ? S_AXI_WDATA  : wdata_q;
        wr_strb   = w_hs  ? S_AXI_WSTRB  : wstrb_q;
        wr_addr32 = '0;
        wr_addr32[AW-1:0] = wr_addr;
        rd_addr32 = '0;
        rd_addr32[AW-1:0] = S_AXI_ARADDR;
        wr_idx32    = reg_index(wr_addr32, IDX_LSB);
        rd_idx32    = reg_index(rd_addr32, IDX_LSB);
        wr_in_range = wr_idx32 < 32'(NUM_REGS);
        rd_in_range = rd_idx32 < 32'(NUM_REGS);
        wr_sel      = wr_idx32[SEL_W-1:0];
        rd_sel      = rd_idx32[SEL_W-1:0];
        old_word    = wr_in_range ? regs_q[wr_sel] : '0;
    end

    axil_regbank_wstrb_merge #(
        .DW(DW)
    ) u_merge (
        .old_i  (old_word),
        .new_i  (wr_data),
        .strb_i (wr_strb),
        .data_o (merged)
    );

    // Write FSM state, holding registers for the early channel, and write response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) awaddr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Storage next state: write-pulse registers self-clear, read-only registers never store.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = W1P_MASK[i] ? '0 : regs_q[i];
        end
        wr_pulse_d = '0;
        if (commit && wr_in_range) begin
            wr_pulse_d[wr_sel] = 1'b1;
            if (!RO_MASK[wr_sel]) regs_d[wr_sel] = merged;
        end
    end

    // Storage and write strobe registers.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Flatten storage onto ctrl_o and unpack status_i.
    always_comb begin
        ctrl_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            ctrl_o[i*DW +: DW] = regs_q[i];
            status_a[i]        = status_i[i*DW +: DW];
        end
    end

    // Read FSM next state and read source selection.
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (S_AXI_ARVALID) rd_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY)  rd_state_d = R_IDLE;
            default:                    rd_state_d = R_IDLE;
        endcase
        rd_word = '0;
        rd_resp = RESP_SLVERR;
        if (rd_in_range) begin
            rd_resp = RESP_OKAY;
            if (RO_MASK[rd_sel])       rd_word = status_a[rd_sel];
            else if (!W1P_MASK[rd_sel]) rd_word = regs_q[rd_sel];
        end
    end

    // Read FSM state and registered read data/response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
        end
    end

endmodule

// File: tb/tb_axil_regbank.sv
// Directed and randomized bench for axil_regbank against a word-array model.
module tb_axil_regbank;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO  = 16'h0004;
    localparam logic [NR-1:0] W1P = 16'h0008;

    logic          clk = 1'b0;
    logic          ARESET = 1'b1;
    logic [AW-1:0] AWADDR = '0;
    logic [2:0]    AWPROT = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [DW-1:0] WDATA = '0;
    logic [3:0]    WSTRB = '0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [AW-1:0] ARADDR = '0;
    logic [2:0]    ARPROT = '0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [NR*DW-1:0] ctrl;
    logic [NR*DW-1:0] status = '0;
    logic [NR-1:0]    wr_pulse;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [NR];

    always #5 clk = ~clk;

    axil_regbank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR),
        .RO_MASK            (RO),
        .W1P_MASK           (W1P)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (ARESET),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWPROT  (AWPROT),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARPROT  (ARPROT),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .ctrl_o        (ctrl),
        .status_i      (status),
        .wr_pulse_o    (wr_pulse)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{s[k]}};
        return m;
    endfunction

    // Expected ctrl_o: model contents, with an optional write-pulse register showing its pulse value.
    function automatic logic [511:0] exp_ctrl(input int pidx, input logic [31:0] pval);
        logic [511:0] r;
        for (int i = 0; i < NR; i++) r[i*32 +: 32] = (i == pidx) ? pval : model[i];
        return r;
    endfunction

    task automatic check_reset_state();
        check("rst_awready", 512'(AWREADY), 512'(1));
        check("rst_wready",  512'(WREADY),  512'(1));
        check("rst_arready", 512'(ARREADY), 512'(1));
        check("rst_bvalid",  512'(BVALID),  512'(0));
        check("rst_rvalid",  512'(RVALID),  512'(0));
        check("rst_bresp",   512'(BRESP),   512'(0));
        check("rst_rresp",   512'(RRESP),   512'(0));
        check("rst_rdata",   512'(RDATA),   512'(0));
        check("rst_pulse",   512'(wr_pulse), 512'(0));
        check("rst_ctrl",    512'(ctrl),    512'(0));
    endtask

    // lead > 0: W goes first by lead cycles; lead < 0: AW goes first.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int bd);
        int idx;
        bit in_range;
        logic [31:0] m, merged, pval;
        int pidx;
        logic [15:0] exp_pulse;
        int aw_start, w_start, t;
        bit aw_done, w_done, aw_hs, w_hs;
        idx       = int'(addr[6:2]);
        in_range  = idx < NR;
        m         = strb_mask(strb);
        pidx      = -1;
        pval      = '0;
        exp_pulse = '0;
        if (in_range) begin
            merged = (model[idx] & ~m) | (data & m);
            exp_pulse[idx] = 1'b1;
            if (idx == 3) begin
                pidx = 3;
                pval = merged;
            end else if (idx != 2) begin
                model[idx] = merged;
            end
        end
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        aw_done = 0; w_done = 0; t = 0;
        while (!(aw_done && w_done) && t < 50) begin
            AWVALID = !aw_done && (t >= aw_start);
            WVALID  = !w_done && (t >= w_start);
            if (aw_done && !w_done) check("awready_low_have_a", 512'(AWREADY), 512'(0));
            if (w_done && !aw_done) check("wready_low_have_d", 512'(WREADY), 512'(0));
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge clk);
            t++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        AWVALID = 0; WVALID = 0;
        check("wr_handshake_done", 512'(aw_done && w_done), 512'(1));
        check("b_valid_rise", 512'(BVALID), 512'(1));
        check("b_resp", 512'(BRESP), 512'(in_range ? 2'b00 : 2'b10));
        check("ctrl_commit", ctrl, exp_ctrl(pidx, pval));
        check("wr_pulse_commit", 512'(wr_pulse), 512'(exp_pulse));
        for (int i = 0; i < bd; i++) begin
            BREADY = 0;
            @(negedge clk);
            check("b_valid_hold", 512'(BVALID), 512'(1));
            check("b_resp_hold", 512'(BRESP), 512'(in_range ? 2'b00 : 2'b10));
            if (i == 0) begin
                check("ctrl_after", ctrl, exp_ctrl(-1, '0));
                check("wr_pulse_after", 512'(wr_pulse), 512'(0));
            end
        end
        BREADY = 1;
        @(negedge clk);
        BREADY = 0;
        if (bd == 0) begin
            check("ctrl_after", ctrl, exp_ctrl(-1, '0));
            check("wr_pulse_after", 512'(wr_pulse), 512'(0));
        end
        check("b_valid_clear", 512'(BVALID), 512'(0));
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int rd, output logic [31:0] got);
        int idx;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        idx = int'(addr[6:2]);
        exp_d = '0;
        exp_r = 2'b10;
        if (idx < NR) begin
            exp_r = 2'b00;
            if (idx == 2)      exp_d = status[64 +: 32];
            else if (idx != 3) exp_d = model[idx];
        end
        ARADDR = addr;
        ARVALID = 1;
        check("ar_ready", 512'(ARREADY), 512'(1));
        @(negedge clk);
        ARVALID = 0;
        check("r_valid_rise", 512'(RVALID), 512'(1));
        check("r_data", 512'(RDATA), 512'(exp_d));
        check("r_resp", 512'(RRESP), 512'(exp_r));
        got = RDATA;
        for (int i = 0; i < rd; i++) begin
            RREADY = 0;
            @(negedge clk);
            check("r_valid_hold", 512'(RVALID), 512'(1));
            check("r_data_hold", 512'(RDATA), 512'(exp_d));
        end
        RREADY = 1;
        @(negedge clk);
        RREADY = 0;
        check("r_valid_clear", 512'(RVALID), 512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        for (int i = 0; i < NR; i++) begin
            model[i] = '0;
            status[i*32 +: 32] = $urandom();
        end
        status[64 +: 32] = 32'hCAFE0001;

        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        ARESET = 0;
        @(negedge clk);

        // Sequential writes then reads.
        for (int i = 0; i < 4; i++) do_write(7'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) do_read(7'(i * 4), 0, got);

        // Byte strobes.
        do_write(7'h00, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_write(7'h00, 32'h12345678, 4'b0101, 0, 1);
        do_read(7'h00, 1, got);
        check("strb_word", 512'(got), 512'(32'hFF34FF78));

        // Channel ordering both ways, unaligned address on the second.
        do_write(7'h04, 32'hA5A5_0004, 4'hF, 3, 0);
        do_write(7'h13, 32'h5A5A_0013, 4'hF, -3, 0);
        do_read(7'h04, 0, got);
        do_read(7'h10, 0, got);

        // Read-only and write-pulse registers.
        do_write(7'h08, 32'h5, 4'hF, 0, 0);
        do_read(7'h08, 0, got);
        check("ro_word", 512'(got), 512'(32'hCAFE0001));
        do_write(7'h0C, 32'h9, 4'hF, 0, 0);
        do_read(7'h0C, 0, got);

        // Out-of-range write with response backpressure, then out-of-range read.
        do_write(7'h40, 32'h7, 4'hF, 0, 5);
        do_read(7'h40, 0, got);

        // Reset while holding an accepted address.
        AWADDR = 7'h14; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1;
        @(negedge clk);
        AWVALID = 0;
        check("mid_awready_have_a", 512'(AWREADY), 512'(0));
        ARESET = 1;
        @(negedge clk);
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_reset_state();
        ARESET = 0;
        @(negedge clk);
        do_read(7'h14, 0, got);
        do_read(7'h00, 0, got);

        // Randomized traffic across in-range and out-of-range addresses.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(7'($urandom_range(0, 71)), $urandom(), 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
            else
                do_read(7'($urandom_range(0, 71)), int'($urandom_range(0, 2)), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
